// File: rtl/param_select_pkg.sv
// Shared definitions for the multi-field parameter editor.
//   CURSOR_NONE : cursor value meaning "no field selected"
//   MAX_FIELDS  : upper limit on NUM_FIELDS (cursor is 4 bits wide)
//   action_e    : the single action chosen per cycle from the button events
package param_select_pkg;

    localparam logic [3:0] CURSOR_NONE = 4'd0;
    localparam int unsigned MAX_FIELDS = 15;

    typedef enum logic [2:0] {
        NONE,
        NAV_R,
        NAV_L,
        INC,
        DEC
    } action_e;

endpackage

// File: rtl/param_select_multi_btn_edge_repeat.sv
// btn_edge_repeat: rising-edge detector for one debounced button, with an
// optional hold-to-repeat generator (macro PARAM_SELECT_AUTOREPEAT_EN).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   btn    : debounced synchronous button, active-high
//   clear  : (autorepeat builds only) restart the repeat delay
//   pulse  : one-cycle event on rising edge (or on a repeat tick)
// Without the macro there is no repeat counter and pulse is the raw edge.
module btn_edge_repeat
    import param_select_pkg::*;
`ifdef PARAM_SELECT_AUTOREPEAT_EN
#(
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
`ifdef PARAM_SELECT_AUTOREPEAT_EN
    input  logic clear,
`endif
    output logic pulse
);

    logic prev;
    logic rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b0;
        else        prev <= btn;
    end

    assign rise = btn & ~prev;

`ifdef PARAM_SELECT_AUTOREPEAT_EN
    generate
        if (REPEAT_EN) begin : g_rep
            localparam int unsigned CNT_MAX =
                (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

            // cnt holds the number of held cycles since the last edge,
            // clear or repeat tick; periodic selects the shorter interval
            // once the first repeat has fired.
            logic [CNT_W-1:0] cnt;
            logic             periodic;
            logic             rep;

            assign rep = btn & prev &
                         (periodic ? (cnt == CNT_W'(REPEAT_PERIOD))
                                   : (cnt == CNT_W'(REPEAT_DELAY)));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt      <= '0;
                    periodic <= 1'b0;
                end else if (!btn) begin
                    cnt      <= '0;
                    periodic <= 1'b0;
                end else if (rise || clear) begin
                    cnt      <= CNT_W'(1);
                    periodic <= 1'b0;
                end else if (rep) begin
                    cnt      <= CNT_W'(1);
                    periodic <= 1'b1;
                end else begin
                    cnt      <= cnt + CNT_W'(1);
                end
            end

            // clear only coincides with a navigation or a lock rise, both of
            // which already void any edit, so masking it here changes nothing.
            assign pulse = (rise | rep) & ~clear;
        end else begin : g_norep
            assign pulse = rise & ~clear;
        end
    endgenerate
`else
    assign pulse = rise;
`endif

endmodule

// File: rtl/param_select_multi.sv
// param_select_multi: cursor-driven editor for NUM_FIELDS bounded fields.
// Right/left move the cursor (0 = none, 1..NUM_FIELDS), up/down edit the
// selected field with per-field wrap or saturation, and the selected field's
// digit mask is presented as a blink mask for the display.
// Ports:
//   clk, reset (async active-low)
//   b_up, b_down, b_right, b_left : debounced buttons, active-high
//   blink_fo     : display blink phase
//   lock         : freeze edits (navigation still works)
//   field_max    : per-field maximum, field i at [i*FIELD_W +: FIELD_W]
//   field_wrap   : per-field 1 = wrap at limits, 0 = saturate
//   field_digits : per-field digit mask, field i at [i*DISP_DIGITS +: DISP_DIGITS]
//   field_val    : current field values
//   cursor       : selected field
//   blink_data   : registered blink mask
//   change_stb   : one-cycle pulse when an edit changed a value
//   change_idx   : cursor value of the changed field
// Optional feature: PARAM_SELECT_AUTOREPEAT_EN enables hold-to-repeat on
// up/down with REPEAT_DELAY / REPEAT_PERIOD parameters.
module param_select_multi #(
    parameter int unsigned NUM_FIELDS    = 7,
    parameter int unsigned FIELD_W       = 5,
    parameter int unsigned DISP_DIGITS   = 16
`ifdef PARAM_SELECT_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              b_up,
    input  logic                              b_down,
    input  logic                              b_right,
    input  logic                              b_left,
    input  logic                              blink_fo,
    input  logic                              lock,
    input  logic [NUM_FIELDS*FIELD_W-1:0]     field_max,
    input  logic [NUM_FIELDS-1:0]             field_wrap,
    input  logic [NUM_FIELDS*DISP_DIGITS-1:0] field_digits,
    output logic [NUM_FIELDS*FIELD_W-1:0]     field_val,
    output logic [3:0]                        cursor,
    output logic [DISP_DIGITS-1:0]            blink_data,
    output logic                              change_stb,
    output logic [3:0]                        change_idx
);

    import param_select_pkg::*;

    logic r_p, l_p, u_p, d_p;

`ifdef PARAM_SELECT_AUTOREPEAT_EN
    logic lock_q;
    logic rep_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lock_q <= 1'b0;
        else        lock_q <= lock;
    end

    assign rep_clear = r_p | l_p | (lock & ~lock_q);

    btn_edge_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_right (.clk(clk), .reset(reset), .btn(b_right), .clear(1'b0), .pulse(r_p));
    btn_edge_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_left  (.clk(clk), .reset(reset), .btn(b_left),  .clear(1'b0), .pulse(l_p));
    btn_edge_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_up    (.clk(clk), .reset(reset), .btn(b_up),    .clear(rep_clear), .pulse(u_p));
    btn_edge_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_down  (.clk(clk), .reset(reset), .btn(b_down),  .clear(rep_clear), .pulse(d_p));
`else
    btn_edge_repeat u_right (.clk(clk), .reset(reset), .btn(b_right), .pulse(r_p));
    btn_edge_repeat u_left  (.clk(clk), .reset(reset), .btn(b_left),  .pulse(l_p));
    btn_edge_repeat u_up    (.clk(clk), .reset(reset), .btn(b_up),    .pulse(u_p));
    btn_edge_repeat u_down  (.clk(clk), .reset(reset), .btn(b_down),  .pulse(d_p));
`endif

    action_e              action;
    logic [FIELD_W-1:0]   val     [NUM_FIELDS];
    logic [FIELD_W-1:0]   val_nxt [NUM_FIELDS];
    logic [FIELD_W-1:0]   mx;
    logic [3:0]           cursor_nxt;
    logic                 stb_nxt;
    logic [3:0]           idx_nxt;
    logic [DISP_DIGITS-1:0] blink_nxt;

    // Right beats left beats up beats down; edits are dropped outright when
    // nothing is selected or the editor is locked.
    always_comb begin
        action = NONE;
        if (r_p)                                              action = NAV_R;
        else if (l_p)                                         action = NAV_L;
        else if (u_p && cursor != CURSOR_NONE && !lock)       action = INC;
        else if (d_p && cursor != CURSOR_NONE && !lock)       action = DEC;
    end

    always_comb begin
        cursor_nxt = cursor;
        stb_nxt    = 1'b0;
        idx_nxt    = CURSOR_NONE;
        mx         = '0;
        case (action)
            NAV_R:   cursor_nxt = (cursor == 4'(NUM_FIELDS)) ? CURSOR_NONE : cursor + 4'd1;
            NAV_L:   cursor_nxt = (cursor == CURSOR_NONE) ? 4'(NUM_FIELDS) : cursor - 4'd1;
            default: cursor_nxt = cursor;
        endcase
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            mx         = field_max[i*FIELD_W +: FIELD_W];
            val_nxt[i] = val[i];
            // An out-of-range value is pulled back silently and takes
            // priority over any edit in the same cycle.
            if (val[i] > mx) begin
                val_nxt[i] = mx;
            end else if (cursor == 4'(i + 1)) begin
                if (action == INC)
                    val_nxt[i] = (val[i] < mx) ? val[i] + FIELD_W'(1)
                                               : (field_wrap[i] ? '0 : val[i]);
                else if (action == DEC)
                    val_nxt[i] = (val[i] != '0) ? val[i] - FIELD_W'(1)
                                                : (field_wrap[i] ? mx : val[i]);
                if (val_nxt[i] != val[i]) begin
                    stb_nxt = 1'b1;
                    idx_nxt = cursor;
                end
            end
        end
    end

    always_comb begin
        blink_nxt = '0;
        if (cursor != CURSOR_NONE && blink_fo) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                if (cursor == 4'(i + 1))
                    blink_nxt = field_digits[i*DISP_DIGITS +: DISP_DIGITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cursor     <= CURSOR_NONE;
            blink_data <= '0;
            change_stb <= 1'b0;
            change_idx <= CURSOR_NONE;
            for (int unsigned i = 0; i < NUM_FIELDS; i++) val[i] <= '0;
        end else begin
            cursor     <= cursor_nxt;
            blink_data <= blink_nxt;
            change_stb <= stb_nxt;
            change_idx <= idx_nxt;
            for (int unsigned i = 0; i < NUM_FIELDS; i++) val[i] <= val_nxt[i];
        end
    end

    always_comb begin
        field_val = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++)
            field_val[i*FIELD_W +: FIELD_W] = val[i];
    end

endmodule
